// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter and its picker.
// Holds FSM state encoding, requester limit and address-width helper.
package mem_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after last_grant.
// Search wraps modulo N; valid is low when no request is pending.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          valid,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] idx;

    // Walk N positions starting one past last_grant; keep the first hit.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = last_grant;
        for (int i = 0; i < N; i++) begin
            idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
            if (req[idx] && !valid) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port, one transaction in flight.
// Optional MEM_ARB_LOCK_EN adds a lock port for back-to-back locked access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256,
    parameter int NUM_REQ   = 2,
    localparam int AW = addr_width(MEM_SIZE),
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*AW-1:0]        req_addr,
    input  logic [NUM_REQ-1:0]           req_write_en,
    input  logic [NUM_REQ-1:0]           req_read_en,
    input  logic [NUM_REQ*MEM_WIDTH-1:0] req_write_val,
    output logic [NUM_REQ-1:0]           ack,
    output logic [MEM_WIDTH-1:0]         read_val,
    output logic [AW-1:0]                mem_addr,
    output logic                         mem_write_en,
    output logic                         mem_read_en,
    output logic [MEM_WIDTH-1:0]         mem_write_val,
    input  logic [MEM_WIDTH-1:0]         mem_read_val
`ifdef MEM_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]           lock
`endif
);

    state_t        state;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] last_grant;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    logic [AW-1:0]        sel_addr;
    logic                 sel_we;
    logic                 sel_re;
    logic [MEM_WIDTH-1:0] sel_wval;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_idx)
    );

    assign sel_addr = req_addr[grant_idx*AW +: AW];
    assign sel_we   = req_write_en[grant_idx];
    assign sel_re   = req_read_en[grant_idx];
    assign sel_wval = req_write_val[grant_idx*MEM_WIDTH +: MEM_WIDTH];

    // Memory port is live only during ACCESS; write beats read.
    always_comb begin
        mem_addr      = '0;
        mem_write_en  = 1'b0;
        mem_read_en   = 1'b0;
        mem_write_val = '0;
        if (state == ST_ACCESS) begin
            mem_addr      = sel_addr;
            mem_write_val = sel_wval;
            mem_write_en  = sel_we;
            mem_read_en   = sel_re && !sel_we;
        end
    end

    // Arbitration FSM with registered grant, ack pulse and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            ack        <= '0;
            read_val   <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    read_val <= (sel_re && !sel_we) ? mem_read_val : '0;
                    ack      <= NUM_REQ'(1) << grant_idx;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
`ifdef MEM_ARB_LOCK_EN
                    if (lock[grant_idx] && req[grant_idx]) begin
                        state <= ST_ACCESS;
                    end else begin
                        last_grant <= grant_idx;
                        state      <= ST_IDLE;
                    end
`else
                    last_grant <= grant_idx;
                    state      <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, queued expectations.
// Define MEM_ARB_LOCK_EN for both bench and RTL to cover locked access.
module tb_mem_arbiter;

    localparam int MW = 32;
    localparam int MS = 256;
    localparam int NR = 2;
    localparam int AW = 8;

    typedef struct {
        logic [NR-1:0] ack;
        logic [MW-1:0] rv;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR-1:0]    req_write_en = '0;
    logic [NR-1:0]    req_read_en = '0;
    logic [NR*MW-1:0] req_write_val = '0;
    logic [NR-1:0]    ack;
    logic [MW-1:0]    read_val;
    logic [AW-1:0]    mem_addr;
    logic             mem_write_en;
    logic             mem_read_en;
    logic [MW-1:0]    mem_write_val;
    logic [MW-1:0]    mem_read_val;
`ifdef MEM_ARB_LOCK_EN
    logic [NR-1:0]    lock = '0;
`endif

    logic [MW-1:0] tb_mem [MS];
    exp_t          sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int re_cyc = 0;
    logic [AW-1:0] we_addr;
    logic [MW-1:0] we_val;

    mem_arbiter #(
        .MEM_WIDTH (MW),
        .MEM_SIZE  (MS),
        .NUM_REQ   (NR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_addr      (req_addr),
        .req_write_en  (req_write_en),
        .req_read_en   (req_read_en),
        .req_write_val (req_write_val),
        .ack           (ack),
        .read_val      (read_val),
        .mem_addr      (mem_addr),
        .mem_write_en  (mem_write_en),
        .mem_read_en   (mem_read_en),
        .mem_write_val (mem_write_val),
        .mem_read_val  (mem_read_val)
`ifdef MEM_ARB_LOCK_EN
        ,
        .lock          (lock)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory controller stub: combinational read, write on clock edge.
    assign mem_read_val = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write_en) tb_mem[mem_addr] <= mem_write_val;
    end

    task automatic check(input string name, input logic [MW-1:0] act,
                         input logic [MW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation; also tallies memory strobes.
    always @(negedge clk) begin
        exp_t e;
        if (mem_write_en) begin
            we_cnt++;
            we_addr = mem_addr;
            we_val  = mem_write_val;
        end
        if (mem_read_en) begin
            re_cnt++;
            re_cyc = cyc;
        end
        if (ack != '0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack=%b with empty queue", ack);
            end else begin
                e = sb_q.pop_front();
                check("ack", {30'd0, ack}, {30'd0, e.ack});
                check("read_val", read_val, e.rv);
            end
        end
    end

    task automatic expect_ack(input logic [NR-1:0] a, input logic [MW-1:0] rv);
        exp_t e;
        e.ack = a;
        e.rv  = rv;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] addr,
                           input logic we, input logic re,
                           input logic [MW-1:0] wv);
        req_addr[k*AW +: AW]      = addr;
        req_write_en[k]           = we;
        req_read_en[k]            = re;
        req_write_val[k*MW +: MW] = wv;
        req[k]                    = 1'b1;
    endtask

    task automatic clear_req(input int k);
        req[k]          = 1'b0;
        req_write_en[k] = 1'b0;
        req_read_en[k]  = 1'b0;
    endtask

    task automatic wait_ack(input int k, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack[k]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: req%0d got no ack required within 20 cycles", k);
        end
    endtask

    initial begin
        int t1, t2, t3, t4, c;
        for (int i = 0; i < MS; i++) tb_mem[i] = '0;
        tb_mem[3] = 32'h0000_0033;
        tb_mem[4] = 32'h0000_0044;
        tb_mem[5] = 32'hDEAD_BEEF;
        tb_mem[9] = 32'h0000_0011;

        // Reset state, with both requesters already asking to read.
        set_req(0, 8'd3, 1'b0, 1'b1, '0);
        set_req(1, 8'd4, 1'b0, 1'b1, '0);
        repeat (2) @(negedge clk);
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_read_val", read_val, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
        check("rst_mem_re", {31'd0, mem_read_en}, 32'd0);
        check("rst_mem_wval", mem_write_val, 32'd0);

        // Contention: 0,1,0,1 each 3 cycles apart.
        expect_ack(2'b01, 32'h33);
        expect_ack(2'b10, 32'h44);
        expect_ack(2'b01, 32'h33);
        expect_ack(2'b10, 32'h44);
        reset = 1'b1;
        wait_ack(0, t1);
        wait_ack(1, t2);
        wait_ack(0, t3);
        wait_ack(1, t4);
        clear_req(0);
        clear_req(1);
        check("rr_gap1", t2 - t1, 32'd3);
        check("rr_gap2", t3 - t2, 32'd3);
        check("rr_gap3", t4 - t3, 32'd3);
        @(negedge clk);

        // Single read with latency and strobe-width checks.
        re_cnt = 0;
        c = cyc;
        set_req(0, 8'd5, 1'b0, 1'b1, '0);
        expect_ack(2'b01, 32'hDEAD_BEEF);
        wait_ack(0, t1);
        clear_req(0);
        check("read_latency", t1 - c, 32'd2);
        check("read_re_cycles", re_cnt, 32'd1);
        check("read_re_when", re_cyc - c, 32'd1);
        @(negedge clk);

        // Requester 1 writes then reads back addr 200.
        we_cnt = 0;
        set_req(1, 8'd200, 1'b1, 1'b0, 32'h1234_5678);
        expect_ack(2'b10, 32'd0);
        wait_ack(1, t1);
        clear_req(1);
        check("wr_we_cycles", we_cnt, 32'd1);
        check("wr_addr", {24'd0, we_addr}, 32'd200);
        check("wr_data", we_val, 32'h1234_5678);
        @(negedge clk);
        set_req(1, 8'd200, 1'b0, 1'b1, '0);
        expect_ack(2'b10, 32'h1234_5678);
        wait_ack(1, t1);
        clear_req(1);
        @(negedge clk);

        // Both enables set: write wins, read_val is 0.
        we_cnt = 0;
        re_cnt = 0;
        set_req(0, 8'd7, 1'b1, 1'b1, 32'h0000_00A5);
        expect_ack(2'b01, 32'd0);
        wait_ack(0, t1);
        clear_req(0);
        check("both_we_cycles", we_cnt, 32'd1);
        check("both_re_cycles", re_cnt, 32'd0);
        @(negedge clk);
        set_req(0, 8'd7, 1'b0, 1'b1, '0);
        expect_ack(2'b01, 32'h0000_00A5);
        wait_ack(0, t1);
        clear_req(0);
        @(negedge clk);

        // Reset in the middle of a write ACCESS.
        set_req(0, 8'd9, 1'b1, 1'b0, 32'h0000_0055);
        @(negedge clk);
        check("mid_we_before", {31'd0, mem_write_en}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_we_after", {31'd0, mem_write_en}, 32'd0);
        check("mid_addr_after", {24'd0, mem_addr}, 32'd0);
        clear_req(0);
        repeat (2) @(negedge clk);
        check("mid_read_val", read_val, 32'd0);
        check("mid_ack", {30'd0, ack}, 32'd0);
        set_req(0, 8'd9, 1'b0, 1'b1, '0);
        set_req(1, 8'd5, 1'b0, 1'b1, '0);
        expect_ack(2'b01, 32'h0000_0011);
        expect_ack(2'b10, 32'hDEAD_BEEF);
        reset = 1'b1;
        wait_ack(0, t1);
        wait_ack(1, t2);
        clear_req(0);
        clear_req(1);
        check("post_rst_gap", t2 - t1, 32'd3);
        @(negedge clk);

`ifdef MEM_ARB_LOCK_EN
        // Locked requester 1 gets three acks 2 cycles apart, then 0 wins.
        set_req(0, 8'd3, 1'b0, 1'b1, '0);
        set_req(1, 8'd4, 1'b0, 1'b1, '0);
        lock = 2'b10;
        expect_ack(2'b01, 32'h33);
        expect_ack(2'b10, 32'h44);
        expect_ack(2'b10, 32'h44);
        expect_ack(2'b10, 32'h44);
        expect_ack(2'b01, 32'h33);
        wait_ack(0, t1);
        wait_ack(1, t2);
        wait_ack(1, t3);
        wait_ack(1, t4);
        lock = 2'b00;
        wait_ack(0, c);
        clear_req(0);
        clear_req(1);
        check("lock_gap1", t3 - t2, 32'd2);
        check("lock_gap2", t4 - t3, 32'd2);
        check("unlock_gap", c - t4, 32'd3);
        @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
